// File: rtl/load_data_unit_if.sv
// Load request / result bundle between the memory stage, the data SRAM read port and writeback.
// master drives requests and SRAM data; slave is the load_data_unit.
interface load_data_unit_if;
  logic        read_enable;
  logic [1:0]  width_ctrl;
  logic        extend_signed;
  logic [31:0] address;
  logic [4:0]  dest_reg;
  logic        stall;
  logic        flush;
  logic [31:0] data_sram_rdata;
  logic [31:0] read_data;
  logic        read_valid;
  logic [4:0]  read_dest_reg;
  logic        busy;
  logic        exception;

  modport master (
    output read_enable, width_ctrl, extend_signed, address, dest_reg, stall, flush,
           data_sram_rdata,
    input  read_data, read_valid, read_dest_reg, busy, exception
  );

  modport slave (
    input  read_enable, width_ctrl, extend_signed, address, dest_reg, stall, flush,
           data_sram_rdata,
    output read_data, read_valid, read_dest_reg, busy, exception
  );
endinterface

// File: rtl/load_data_unit.sv
// Load formatter: captures request attributes, formats the SRAM word one cycle later and holds it
// until writeback takes it. Define LOAD_ALIGN_CHECK_EN to drop misaligned loads with an exception.
module load_data_unit (
  input logic              clk,
  input logic              reset,
  load_data_unit_if.slave  bus
);

  localparam logic [1:0] MemWidth1 = 2'b00;
  localparam logic [1:0] MemWidth2 = 2'b01;
  localparam logic [1:0] MemWidth4 = 2'b10;

  typedef enum logic [1:0] {StIdle, StWait, StValid} state_e;

  state_e      state_q, state_d;
  logic [1:0]  width_q;
  logic [1:0]  addr_q;
  logic        signed_q;
  logic [4:0]  dest_q;
  logic [31:0] data_q, data_d;
  logic [4:0]  rdest_q;
  logic        valid_q;

  logic req_ok, misaligned, accept, busy;
  logic unused_addr;

  assign unused_addr = ^bus.address[31:2];

  always_comb begin
    misaligned = 1'b0;
`ifdef LOAD_ALIGN_CHECK_EN
    case (bus.width_ctrl)
      MemWidth1: misaligned = 1'b0;
      MemWidth2: misaligned = bus.address[0];
      default:   misaligned = (bus.address[1:0] != 2'b00);
    endcase
`endif
  end

  assign busy   = (state_q == StWait) || ((state_q == StValid) && bus.stall);
  assign req_ok = bus.read_enable && !busy && !bus.flush;
  assign accept = req_ok && !misaligned;

  // Lane selection and extension from the latched attributes.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b      = bus.data_sram_rdata[{addr_q, 3'b000} +: 8];
    h      = addr_q[1] ? bus.data_sram_rdata[31:16] : bus.data_sram_rdata[15:0];
    data_d = bus.data_sram_rdata;
    case (width_q)
      MemWidth1: data_d = {{24{signed_q & b[7]}}, b};
      MemWidth2: data_d = {{16{signed_q & h[15]}}, h};
      MemWidth4: data_d = bus.data_sram_rdata;
      default:   data_d = bus.data_sram_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StWait;
      StWait:  state_d = StValid;
      StValid: if (!bus.stall) state_d = accept ? StWait : StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      width_q  <= MemWidth4;
      addr_q   <= 2'b00;
      signed_q <= 1'b0;
      dest_q   <= 5'd0;
      data_q   <= 32'd0;
      rdest_q  <= 5'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == StValid);
      if (accept) begin
        width_q  <= bus.width_ctrl;
        addr_q   <= bus.address[1:0];
        signed_q <= bus.extend_signed;
        dest_q   <= bus.dest_reg;
      end
      if ((state_q == StWait) && !bus.flush) begin
        data_q  <= data_d;
        rdest_q <= dest_q;
      end
    end
  end

  assign bus.read_data     = data_q;
  assign bus.read_valid    = valid_q;
  assign bus.read_dest_reg = rdest_q;
  assign bus.busy          = busy;
  assign bus.exception     = req_ok && misaligned;

endmodule

// File: tb/tb_load_data_unit.sv
// Scoreboard bench for load_data_unit: directed cases then randomized loads against a
// arithmetic formatting model; a monitor pops expected results when writeback consumes them.
module tb_load_data_unit;

  localparam logic [1:0] W1 = 2'b00;
  localparam logic [1:0] W2 = 2'b01;
  localparam logic [1:0] W4 = 2'b10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_data_unit_if bus();

  load_data_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dest;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] w, input logic s,
                                        input logic [31:0] a, input logic [31:0] rd);
    int          sh;
    logic [31:0] mask, v;
    if (w == W1) begin
      sh   = int'(a[1:0]) * 8;
      mask = 32'hFF;
    end else if (w == W2) begin
      sh   = int'(a[1]) * 16;
      mask = 32'hFFFF;
    end else begin
      return rd;
    end
    v = (rd >> sh) & mask;
    if (s && (v > (mask >> 1))) v = v | ~mask;
    return v;
  endfunction

  function automatic logic misal(input logic [1:0] w, input logic [31:0] a);
`ifdef LOAD_ALIGN_CHECK_EN
    if (w == W1) return 1'b0;
    if (w == W2) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.read_enable = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    cyc();
  endtask

  // fmode: 0 = normal, 1 = flush in wait, 2 = flush in valid after the stall cycles.
  // Returns in the consumption cycle (fmode 0) so the caller may chain a new request.
  task automatic do_load(input logic [1:0] w, input logic s, input logic [31:0] a,
                         input logic [4:0] d, input logic [31:0] rd, input int nstall,
                         input int fmode);
    logic [31:0] ev;
    logic        bad;
    exp_t        e;
    ev = model(w, s, a, rd);
    bad = misal(w, a);
    bus.read_enable     = 1'b1;
    bus.width_ctrl      = w;
    bus.extend_signed   = s;
    bus.address         = a;
    bus.dest_reg        = d;
    bus.stall           = 1'b0;
    bus.flush           = 1'b0;
    bus.data_sram_rdata = $urandom;
    @(negedge clk);
    chk("req_busy", {31'd0, bus.busy}, 32'd0);
    chk("req_exception", {31'd0, bus.exception}, {31'd0, bad});
    cyc();
    bus.read_enable   = 1'b0;
    bus.width_ctrl    = 2'($urandom);
    bus.extend_signed = 1'($urandom);
    bus.address       = $urandom;
    bus.dest_reg      = 5'($urandom);
    if (bad) begin
      repeat (3) begin
        @(negedge clk);
        chk("dropped_valid", {31'd0, bus.read_valid}, 32'd0);
        chk("dropped_busy", {31'd0, bus.busy}, 32'd0);
        cyc();
      end
      return;
    end
    if (fmode == 0) begin
      e.data = ev;
      e.dest = d;
      sb.push_back(e);
    end
    bus.data_sram_rdata = rd;
    bus.flush           = (fmode == 1);
    @(negedge clk);
    chk("wait_busy", {31'd0, bus.busy}, 32'd1);
    cyc();
    bus.flush           = 1'b0;
    bus.data_sram_rdata = $urandom;
    if (fmode == 1) begin
      @(negedge clk);
      chk("flushed_wait_valid", {31'd0, bus.read_valid}, 32'd0);
      chk("flushed_wait_busy", {31'd0, bus.busy}, 32'd0);
      cyc();
      return;
    end
    for (int i = 0; i < nstall; i++) begin
      bus.stall = 1'b1;
      @(negedge clk);
      chk("stall_valid", {31'd0, bus.read_valid}, 32'd1);
      chk("stall_busy", {31'd0, bus.busy}, 32'd1);
      chk("stall_data", bus.read_data, ev);
      chk("stall_dest", {27'd0, bus.read_dest_reg}, {27'd0, d});
      cyc();
      bus.data_sram_rdata = $urandom;
    end
    bus.stall = 1'b0;
    if (fmode == 2) begin
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flushed_valid_valid", {31'd0, bus.read_valid}, 32'd0);
      cyc();
    end
  endtask

  // Monitor: a result is consumed when valid and writeback is neither stalled nor flushing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.read_valid === 1'b1 && bus.stall === 1'b0 &&
          bus.flush === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got data %08h dest %0d expected none at %0t",
                   bus.read_data, bus.read_dest_reg, $time);
        end else begin
          e = sb.pop_front();
          chk("result_data", bus.read_data, e.data);
          chk("result_dest", {27'd0, bus.read_dest_reg}, {27'd0, e.dest});
        end
      end
    end
  end

  initial begin
    reset               = 1'b0;
    bus.read_enable     = 1'b1;
    bus.width_ctrl      = W4;
    bus.extend_signed   = 1'b0;
    bus.address         = 32'h0;
    bus.dest_reg        = 5'd3;
    bus.stall           = 1'b0;
    bus.flush           = 1'b0;
    bus.data_sram_rdata = 32'h1234_5678;

    // Reset held with a request asserted.
    repeat (2) begin
      cyc();
      @(negedge clk);
      chk("rst_data", bus.read_data, 32'd0);
      chk("rst_valid", {31'd0, bus.read_valid}, 32'd0);
      chk("rst_dest", {27'd0, bus.read_dest_reg}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_exception", {31'd0, bus.exception}, 32'd0);
    end
    cyc();
    reset           = 1'b1;
    bus.read_enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, bus.read_valid}, 32'd0);
      cyc();
    end

    // Directed formatting cases.
    do_load(W1, 1'b1, 32'h0000_1003, 5'd5, 32'h80FF_1234, 1, 0);
    idle();
    do_load(W2, 1'b0, 32'h0000_2002, 5'd6, 32'h9ABC_5678, 0, 0);
    idle();
    do_load(W2, 1'b1, 32'h0000_2002, 5'd6, 32'h9ABC_5678, 0, 0);
    idle();

    // Stall three cycles, then release with a chained request.
    do_load(W4, 1'b0, 32'h0000_0000, 5'd7, 32'hDEAD_BEEF, 3, 0);
    do_load(W1, 1'b0, 32'h0000_0001, 5'd8, 32'h0000_A500, 1, 0);
    idle();

    // Flushes in WAIT and in VALID.
    do_load(W4, 1'b0, 32'h0, 5'd9, 32'h1111_2222, 0, 1);
    do_load(W4, 1'b0, 32'h0, 5'd10, 32'h3333_4444, 2, 2);

    // Flush with a simultaneous request: nothing captured.
    bus.read_enable = 1'b1;
    bus.flush       = 1'b1;
    bus.width_ctrl  = W4;
    bus.address     = 32'h2;
    @(negedge clk);
    chk("flush_req_exception", {31'd0, bus.exception}, 32'd0);
    cyc();
    bus.read_enable = 1'b0;
    bus.flush       = 1'b0;
    @(negedge clk);
    chk("flush_req_busy", {31'd0, bus.busy}, 32'd0);
    cyc();
    @(negedge clk);
    chk("flush_req_valid", {31'd0, bus.read_valid}, 32'd0);
    cyc();

    // Reset in the middle of WAIT discards the load.
    bus.read_enable = 1'b1;
    bus.width_ctrl  = W4;
    bus.address     = 32'h0;
    cyc();
    bus.read_enable = 1'b0;
    reset           = 1'b0;
    cyc();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, bus.read_valid}, 32'd0);
      cyc();
    end

    // Misaligned word.
    do_load(W4, 1'b1, 32'h0000_1002, 5'd11, 32'h8765_4321, 0, 0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      do_load(2'($urandom_range(0, 3)), 1'($urandom), $urandom, 5'($urandom), $urandom,
              int'($urandom_range(0, 3)), (r < 8) ? 0 : (r == 8) ? 1 : 2);
      if ($urandom_range(0, 1) == 1) idle();
    end

    repeat (3) idle();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
